// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine with byte-lane steering, sign extension and timeout abort
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        lsu_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t state;
    logic is_load;
    logic [2:0] f3_q;
    logic [1:0] off_q;
    logic [CW-1:0] cnt;
    logic req, f3_ok, aligned, legal, timeout;
    logic [3:0] be_n;
    logic [31:0] wdata_n, ext;
    logic [7:0] rbyte;
    logic [15:0] rhalf;

    // request legality, store lane steering, load extraction and the stall output
    always_comb begin
        req = mem_rd_en | mem_wr_en;
        f3_ok = mem_rd_en ? (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd2 || funct3 == 3'd4 || funct3 == 3'd5)
                          : (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd2);
        aligned = (funct3[1:0] == 2'b01) ? !addr[0] : (funct3[1:0] == 2'b10) ? (addr[1:0] == 2'b00) : 1'b1;
        legal = req & f3_ok & aligned;
        be_n = (funct3[1:0] == 2'b00) ? 4'b0001 << addr[1:0] : (funct3[1:0] == 2'b01) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_n = (funct3[1:0] == 2'b00) ? {4{store_data[7:0]}} : (funct3[1:0] == 2'b01) ? {2{store_data[15:0]}} : store_data;
        rbyte = off_q[1] ? (off_q[0] ? dmem_rdata[31:24] : dmem_rdata[23:16]) : (off_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]);
        rhalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ext = (f3_q == 3'd0) ? {{24{rbyte[7]}}, rbyte} :
              (f3_q == 3'd4) ? {24'd0, rbyte} :
              (f3_q == 3'd1) ? {{16{rhalf[15]}}, rhalf} :
              (f3_q == 3'd5) ? {16'd0, rhalf} : dmem_rdata;
        timeout = (cnt == CW'(TIMEOUT_CYCLES));
        lsu_stall = !rst && ((state == IDLE && legal) || state == REQ || state == WAIT);
    end

    // transaction FSM with registered memory-side outputs and result strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            is_load    <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            lsu_fault  <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            lsu_fault  <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        state      <= REQ;
                        is_load    <= mem_rd_en;
                        f3_q       <= funct3;
                        off_q      <= addr[1:0];
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= !mem_rd_en;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= be_n;
                        dmem_wdata <= wdata_n;
                    end else if (req) begin
                        lsu_fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (timeout) begin
                        dmem_req  <= 1'b0;
                        lsu_fault <= 1'b1;
                        state     <= DONE;
                    end else if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        cnt      <= cnt + 1'b1;
                        state    <= is_load ? WAIT : DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (timeout) begin
                        lsu_fault <= 1'b1;
                        state     <= DONE;
                    end else if (dmem_rvalid) begin
                        load_data  <= ext;
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store, fault, timeout and reset checks
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_en, mem_wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        lsu_stall, load_valid, lsu_fault;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    int errors = 0;
    int checks = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .lsu_stall(lsu_stall), .load_data(load_data), .load_valid(load_valid),
        .lsu_fault(lsu_fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
        mem_rd_en = 1'b1; funct3 = f3; addr = a;
        @(negedge clk);
        mem_rd_en = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check(tag, load_data, exp);
        check({tag, "_valid"}, {31'd0, load_valid}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; mem_rd_en = 0; mem_wr_en = 0; funct3 = 0; addr = 0; store_data = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        @(negedge clk);
        mem_rd_en = 1'b1; funct3 = 3'd2; addr = 32'h100;
        #1;
        check("rst_stall", {31'd0, lsu_stall}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_data", load_data, 32'd0);
        check("rst_valid_fault", {30'd0, load_valid, lsu_fault}, 32'd0);
        mem_rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LW with zero wait states: stall cycles 1-3, load_valid in cycle 4
        mem_rd_en = 1'b1; funct3 = 3'd2; addr = 32'h100;
        #1 check("lw_c1_stall", {31'd0, lsu_stall}, 32'd1);
        @(negedge clk);
        mem_rd_en = 1'b0; dmem_gnt = 1'b1;
        #1;
        check("lw_c2_req", {31'd0, dmem_req}, 32'd1);
        check("lw_c2_addr", dmem_addr, 32'h100);
        check("lw_c2_we", {31'd0, dmem_we}, 32'd0);
        check("lw_c2_stall", {31'd0, lsu_stall}, 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("lw_c3_req", {31'd0, dmem_req}, 32'd0);
        check("lw_c3_stall", {31'd0, lsu_stall}, 32'd1);
        check("lw_c3_valid", {31'd0, load_valid}, 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("lw_c4_data", load_data, 32'hDEADBEEF);
        check("lw_c4_valid", {31'd0, load_valid}, 32'd1);
        check("lw_c4_stall", {31'd0, lsu_stall}, 32'd0);
        @(negedge clk);
        check("lw_c5_valid", {31'd0, load_valid}, 32'd0);

        do_load("lb", 3'd0, 32'h103, 32'h80123456, 32'hFFFFFF80);
        do_load("lbu", 3'd4, 32'h103, 32'h80123456, 32'h00000080);
        do_load("lb1", 3'd0, 32'h101, 32'h80123456, 32'h00000034);
        do_load("lh", 3'd1, 32'h102, 32'h80123456, 32'hFFFF8012);
        do_load("lhu", 3'd5, 32'h102, 32'h80123456, 32'h00008012);
        do_load("lh0", 3'd1, 32'h100, 32'h0000F00D, 32'hFFFFF00D);

        // SH with one cycle of grant delay: request fields must hold
        mem_wr_en = 1'b1; funct3 = 3'd1; addr = 32'h102; store_data = 32'h0000ABCD;
        @(negedge clk);
        mem_wr_en = 1'b0; store_data = 32'h11111111;
        check("sh_be", {28'd0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hABCDABCD);
        check("sh_addr", dmem_addr, 32'h100);
        check("sh_we", {31'd0, dmem_we}, 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b1;
        check("sh_hold_req", {31'd0, dmem_req}, 32'd1);
        check("sh_hold_be", {28'd0, dmem_be}, 32'hC);
        check("sh_hold_wdata", dmem_wdata, 32'hABCDABCD);
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("sh_done_req", {31'd0, dmem_req}, 32'd0);
        check("sh_done_valid", {31'd0, load_valid}, 32'd0);
        check("sh_done_stall", {31'd0, lsu_stall}, 32'd0);
        @(negedge clk);

        // SB lane steering
        mem_wr_en = 1'b1; funct3 = 3'd0; addr = 32'h201; store_data = 32'h12345678;
        @(negedge clk);
        mem_wr_en = 1'b0; dmem_gnt = 1'b1;
        check("sb_be", {28'd0, dmem_be}, 32'h2);
        check("sb_wdata", dmem_wdata, 32'h78787878);
        @(negedge clk);
        dmem_gnt = 1'b0;
        @(negedge clk);

        // both enables: treated as a load
        mem_rd_en = 1'b1; mem_wr_en = 1'b1; funct3 = 3'd2; addr = 32'h300;
        @(negedge clk);
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; dmem_gnt = 1'b1;
        check("both_we", {31'd0, dmem_we}, 32'd0);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("both_data", load_data, 32'hCAFEF00D);
        @(negedge clk);

        // misaligned LW
        mem_rd_en = 1'b1; funct3 = 3'd2; addr = 32'h101;
        #1 check("mis_stall", {31'd0, lsu_stall}, 32'd0);
        @(negedge clk);
        mem_rd_en = 1'b0;
        check("mis_fault", {31'd0, lsu_fault}, 32'd1);
        check("mis_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        check("mis_fault_pulse", {31'd0, lsu_fault}, 32'd0);
        check("mis_req2", {31'd0, dmem_req}, 32'd0);

        // store with a load-only funct3 is illegal
        mem_wr_en = 1'b1; funct3 = 3'd4; addr = 32'h100;
        #1 check("ill_stall", {31'd0, lsu_stall}, 32'd0);
        @(negedge clk);
        mem_wr_en = 1'b0;
        check("ill_fault", {31'd0, lsu_fault}, 32'd1);
        check("ill_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);

        // timeout with grant held low
        mem_rd_en = 1'b1; funct3 = 3'd2; addr = 32'h400;
        @(negedge clk);
        mem_rd_en = 1'b0;
        check("to_req", {31'd0, dmem_req}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (lsu_fault) seen = 1'b1;
        end
        check("to_fault", {31'd0, seen}, 32'd1);
        check("to_req_drop", {31'd0, dmem_req}, 32'd0);
        check("to_valid", {31'd0, load_valid}, 32'd0);
        @(negedge clk);
        check("to_fault_pulse", {31'd0, lsu_fault}, 32'd0);

        // rvalid in IDLE is ignored
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("idle_rvalid", {31'd0, load_valid}, 32'd0);

        // reset while in WAIT
        mem_rd_en = 1'b1; funct3 = 3'd2; addr = 32'h500;
        @(negedge clk);
        mem_rd_en = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check("wrst_stall", {31'd0, lsu_stall}, 32'd0);
        check("wrst_outs", {26'd0, dmem_req, dmem_we, dmem_be}, 32'd0);
        check("wrst_data", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h77777777;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            if (load_valid || lsu_fault || dmem_req) seen = 1'b1;
        end
        check("wrst_no_strobe", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max cycles a data-memory transaction may stay outstanding before abort.
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_rd_en  in  1  load request from control decode.
REQ-005 SHALL have port mem_wr_en  in  1  store request from control decode.
REQ-006 SHALL have port funct3  in  3  access size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-007 SHALL have port addr  in  32  effective byte address from the ALU.
REQ-008 SHALL have port store_data  in  32  rs2 value.
REQ-009 SHALL have port lsu_stall  out  1  holds the pipeline while high.
REQ-010 SHALL have port load_data  out  32  extended load result.
REQ-011 SHALL have port load_valid  out  1  one-cycle strobe qualifying load_data.
REQ-012 SHALL have port lsu_fault  out  1  one-cycle strobe: misaligned, illegal funct3 or timeout.
REQ-013 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_be out 4: data-memory request.
REQ-014 SHALL have ports dmem_gnt in 1, dmem_rvalid in 1, dmem_rdata in 32: data-memory grant and read response.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-016 In IDLE, mem_rd_en or mem_wr_en with legal funct3 and aligned addr SHALL latch op, funct3, addr, store_data and move to REQ next cycle.
REQ-017 mem_rd_en and mem_wr_en both high SHALL be treated as a load; the store is ignored.
REQ-018 Legal funct3: loads 0,1,2,4,5; stores 0,1,2. Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
REQ-019 An illegal or misaligned request in IDLE SHALL pulse lsu_fault the next cycle, issue no dmem_req, assert no stall, and stay in IDLE.
REQ-020 lsu_stall SHALL be combinational: high when (IDLE and a legal request is present) or state is REQ or WAIT; low in DONE.
REQ-021 In REQ, dmem_req SHALL be 1 and dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL be held stable until the cycle dmem_gnt=1.
REQ-022 On grant, a store SHALL go to DONE and a load SHALL go to WAIT; dmem_req SHALL drop the cycle after grant.
REQ-023 In WAIT, dmem_rvalid=1 SHALL register the extended data into load_data and go to DONE.
REQ-024 dmem_rvalid outside WAIT SHALL be ignored.
REQ-025 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-026 In DONE, load_valid=1 for a completed load and 0 for a store. No new request SHALL be captured in DONE.
REQ-027 dmem_addr SHALL be {addr[31:2],2'b00}.
REQ-028 dmem_be: SB = 4'b0001 shifted left by addr[1:0]; SH = 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); SW = 4'b1111.
REQ-029 dmem_wdata: SB replicates store_data[7:0] four times; SH replicates store_data[15:0] twice; SW passes store_data unchanged.
REQ-030 Load extraction SHALL select the byte/half at addr[1:0]/addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-031 A counter SHALL clear on entering REQ and increment each cycle in REQ or WAIT.
REQ-032 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with lsu_fault=1 and load_valid=0, and drop dmem_req.
REQ-033 Back-to-back accesses: a new request is accepted in the first IDLE cycle after DONE, giving a minimum load latency of 4 cycles at zero wait.

Reset
REQ-034 rst=1 SHALL immediately force IDLE and set dmem_req, dmem_we, dmem_be, load_valid, lsu_fault to 0, load_data to 0 and the counter to 0.
REQ-035 lsu_stall SHALL be 0 during reset. Reset mid-transaction SHALL abandon the access with no strobe after release.

Verification
REQ-036 LW addr=0x100, gnt same cycle, rvalid 1 cycle later with rdata=0xDEADBEEF -> load_data=0xDEADBEEF, load_valid in cycle 4, stall high for cycles 1-3.
REQ-037 LB addr=0x103, rdata=0x80123456 -> load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr=0x102, store_data=0x0000ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x100, load_valid stays 0.
REQ-039 LW addr=0x101 -> lsu_fault pulse, dmem_req never asserted, lsu_stall stays 0.
REQ-040 With TIMEOUT_CYCLES=4 and gnt held 0 -> lsu_fault pulses in DONE and dmem_req drops; rst asserted in WAIT -> all outputs 0 with no load_valid afterwards.
